// File: rtl/link_defs_pkg.sv
// ---------------------------------------------------------------------------
// link_defs_pkg
// Definitions shared by both ends of the serial link. The transmit-side idle
// inserter and the receive-side deserializer use the same COM symbol.
//   LINK_WIDTH : byte width carried over the link
//   LINK_COM   : idle / comma symbol used for byte alignment
//   rx_state_t : receiver alignment state encoding
// ---------------------------------------------------------------------------
package link_defs_pkg;

  localparam int         LINK_WIDTH = 8;
  localparam logic [7:0] LINK_COM   = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    ALIGNING = 2'd1,
    LOCKED   = 2'd2
  } rx_state_t;

  // True when a received byte is the idle symbol.
  function automatic logic is_com(input logic [7:0] b, input logic [7:0] com);
    return (b == com);
  endfunction

endpackage

// File: rtl/serial_to_parallel_rx_shift_in_reg.sv
// ---------------------------------------------------------------------------
// shift_in_reg
// WIDTH-bit MSB-first shift register. The value the register will hold after
// the current edge is exposed combinationally as nxt, so the FSM can act on a
// complete byte at the very edge that samples its last bit.
// Ports:
//   clk      : rising-edge clock
//   reset_L  : synchronous active-low reset (clears the register)
//   data_in  : serial bit
//   nxt      : {current contents without MSB, data_in}
// ---------------------------------------------------------------------------
module shift_in_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             data_in,
  output logic [WIDTH-1:0] nxt
);

  logic [WIDTH-1:0] sr;

  // Incoming bit enters at the LSB; older bits move toward the MSB.
  always_comb begin
    nxt = {sr[WIDTH-2:0], data_in};
  end

  // Shift register update.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      sr <= {WIDTH{1'b0}};
    end else begin
      sr <= nxt;
    end
  end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// ---------------------------------------------------------------------------
// serial_to_parallel_rx
// Deserializes an MSB-first bit stream on dclk. Hunts for the COM symbol at
// bit granularity, confirms alignment over COM_LOCK consecutive aligned COMs,
// then delivers every byte with a one-cycle strobe. Alignment is frozen once
// locked; only reset releases it.
// Ports:
//   dclk        : serial bit clock, all logic on the rising edge
//   reset_L     : synchronous active-low reset
//   data_in     : serial bit, MSB of each byte first
//   data_out    : last received byte, held between strobes
//   valid_out   : 1 for a data byte, 0 for a COM idle byte, held
//   byte_strobe : one-dclk pulse when data_out/valid_out update
//   active      : high while locked
// ---------------------------------------------------------------------------
module serial_to_parallel_rx
  import link_defs_pkg::*;
#(
  parameter int             WIDTH    = LINK_WIDTH,
  parameter logic [WIDTH-1:0] COM    = WIDTH'(LINK_COM),
  parameter int             COM_LOCK = 4
) (
  input  logic             dclk,
  input  logic             reset_L,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             byte_strobe,
  output logic             active
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       LOCK_CNT = 4'(COM_LOCK);

  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [3:0]       com_cnt, com_cnt_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt;
  logic             strobe_nxt;
  logic             active_nxt;

  logic [WIDTH-1:0] nxt;
  logic             nxt_is_com;
  logic             at_boundary;
  logic [CNT_W-1:0] bit_wrap;
  logic [3:0]       com_inc;

  shift_in_reg #(
    .WIDTH (WIDTH)
  ) u_shift_in_reg (
    .clk     (dclk),
    .reset_L (reset_L),
    .data_in (data_in),
    .nxt     (nxt)
  );

  // Helper terms shared by the FSM branches.
  always_comb begin
    nxt_is_com  = (nxt == COM);
    at_boundary = (bit_cnt == LAST_BIT);
    bit_wrap    = at_boundary ? {CNT_W{1'b0}} : (bit_cnt + CNT_W'(1));
    com_inc     = com_cnt + 4'd1;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    com_cnt_nxt = com_cnt;
    data_nxt    = data_out;
    valid_nxt   = valid_out;
    strobe_nxt  = 1'b0;
    active_nxt  = active;
    case (state)
      SEARCH: begin
        // Any bit position may start a byte; the match edge becomes bit 7.
        if (nxt_is_com) begin
          bit_cnt_nxt = {CNT_W{1'b0}};
          com_cnt_nxt = 4'd1;
          if (COM_LOCK == 1) begin
            state_nxt  = LOCKED;
            active_nxt = 1'b1;
          end else begin
            state_nxt = ALIGNING;
          end
        end else begin
          bit_cnt_nxt = {CNT_W{1'b0}};
        end
      end
      ALIGNING: begin
        bit_cnt_nxt = bit_wrap;
        if (at_boundary) begin
          if (nxt_is_com) begin
            com_cnt_nxt = com_inc;
            if (com_inc == LOCK_CNT) begin
              state_nxt  = LOCKED;
              active_nxt = 1'b1;
            end else begin
              state_nxt = ALIGNING;
            end
          end else begin
            com_cnt_nxt = 4'd0;
            state_nxt   = SEARCH;
          end
        end else begin
          state_nxt = ALIGNING;
        end
      end
      LOCKED: begin
        // Alignment is frozen; straddling COM patterns are just data bits.
        bit_cnt_nxt = bit_wrap;
        if (at_boundary) begin
          data_nxt   = nxt;
          valid_nxt  = !is_com(8'(nxt), 8'(COM));
          strobe_nxt = 1'b1;
        end else begin
          strobe_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt   = SEARCH;
        bit_cnt_nxt = {CNT_W{1'b0}};
        com_cnt_nxt = 4'd0;
        active_nxt  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; reset wins in every state.
  always_ff @(posedge dclk) begin
    if (!reset_L) begin
      state       <= SEARCH;
      bit_cnt     <= {CNT_W{1'b0}};
      com_cnt     <= 4'd0;
      data_out    <= {WIDTH{1'b0}};
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      com_cnt     <= com_cnt_nxt;
      data_out    <= data_nxt;
      valid_out   <= valid_nxt;
      byte_strobe <= strobe_nxt;
      active      <= active_nxt;
    end
  end

endmodule
